// File: rtl/fb_swap_controller_if.sv
// Rasterizer / LCD / frame-buffer-reader side signals of the triple-buffer swap controller.
// The controller connects through the slave modport; the master modport is the environment's view.
interface fb_swap_controller_if;
   logic        lcd_next_frame;
   logic        draw_start;
   logic        draw_done;
   logic        draw_grant;
   logic [29:0] back_address;
   logic [29:0] front_address;
   logic [1:0]  front_index;
   logic        pending;
   logic [15:0] swap_count;
   logic [15:0] drop_count;
   logic        protocol_error;

   modport slave (
      input  lcd_next_frame,
      input  draw_start,
      input  draw_done,
      output draw_grant,
      output back_address,
      output front_address,
      output front_index,
      output pending,
      output swap_count,
      output drop_count,
      output protocol_error
   );

   modport master (
      output lcd_next_frame,
      output draw_start,
      output draw_done,
      input  draw_grant,
      input  back_address,
      input  front_address,
      input  front_index,
      input  pending,
      input  swap_count,
      input  drop_count,
      input  protocol_error
   );
endinterface

// File: rtl/fb_swap_controller.sv
// Triple-buffer scheduler: front (scanned out), spare (latest finished frame), back (being drawn).
// Optional macro FB_SWAP_THROTTLE_EN: stall new draws in WAIT_SPARE instead of dropping frames.
module fb_swap_controller #(
   parameter logic [29:0] FB_ADDRESS = 30'h3800_0000,
   parameter int unsigned FB_LENGTH  = 1536000
) (
   input  logic                  clock,
   input  logic                  reset_n,
   fb_swap_controller_if.slave   bus
);

`ifdef FB_SWAP_THROTTLE_EN
   typedef enum logic [1:0] {IDLE = 2'd0, DRAWING = 2'd1, WAIT_SPARE = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, DRAWING = 2'd1} state_t;
`endif

   state_t      state_reg, state_next;
   logic [1:0]  front_reg, front_next;
   logic [1:0]  spare_reg, spare_next;
   logic [1:0]  back_reg, back_next;
   logic        pending_reg, pending_next;
   logic        grant_reg;
   logic [15:0] swap_reg, swap_next;
   logic [15:0] drop_reg, drop_next;
   logic        perr_reg, perr_next;
   logic [29:0] front_addr_reg, back_addr_reg;
   logic        done_ev;

   // Entry 3 is never selected; it only keeps the 2-bit lookup fully populated.
   logic [29:0] base_addr [4];
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_base
         assign base_addr[gi] = FB_ADDRESS + 30'(gi * FB_LENGTH);
      end
   endgenerate

   always_comb begin
      state_next   = state_reg;
      front_next   = front_reg;
      spare_next   = spare_reg;
      back_next    = back_reg;
      pending_next = pending_reg;
      swap_next    = swap_reg;
      drop_next    = drop_reg;
      perr_next    = perr_reg;
      done_ev      = 1'b0;

      case (state_reg)
         IDLE: begin
            if (bus.draw_start) begin
`ifdef FB_SWAP_THROTTLE_EN
               if (pending_reg) state_next = WAIT_SPARE;
               else             state_next = DRAWING;
`else
               state_next = DRAWING;
`endif
            end
         end
         DRAWING: begin
            if (bus.draw_done) begin
               done_ev    = 1'b1;
               state_next = IDLE;
            end
         end
`ifdef FB_SWAP_THROTTLE_EN
         // Spare is freed by the promoting frame pulse; start drawing one cycle later.
         WAIT_SPARE: begin
            if (!pending_reg) state_next = DRAWING;
         end
`endif
         default: state_next = IDLE;
      endcase

      if (bus.draw_done && (state_reg != DRAWING)) perr_next = 1'b1;

      // Completed frame goes to spare; an undisplayed spare frame becomes the new back.
      if (done_ev) begin
         spare_next   = back_reg;
         back_next    = spare_reg;
         pending_next = 1'b1;
         if (pending_reg) drop_next = drop_reg + 16'd1;
      end

      // Evaluated after draw_done so a frame finished on this edge is promoted at once.
      if (bus.lcd_next_frame && pending_next) begin
         front_next   = spare_next;
         spare_next   = front_reg;
         pending_next = 1'b0;
         swap_next    = swap_reg + 16'd1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg      <= IDLE;
         front_reg      <= 2'd0;
         spare_reg      <= 2'd1;
         back_reg       <= 2'd2;
         pending_reg    <= 1'b0;
         grant_reg      <= 1'b0;
         swap_reg       <= 16'd0;
         drop_reg       <= 16'd0;
         perr_reg       <= 1'b0;
         front_addr_reg <= FB_ADDRESS;
         back_addr_reg  <= FB_ADDRESS + 30'(2 * FB_LENGTH);
      end else begin
         state_reg      <= state_next;
         front_reg      <= front_next;
         spare_reg      <= spare_next;
         back_reg       <= back_next;
         pending_reg    <= pending_next;
         grant_reg      <= (state_next == DRAWING);
         swap_reg       <= swap_next;
         drop_reg       <= drop_next;
         perr_reg       <= perr_next;
         front_addr_reg <= base_addr[front_next];
         back_addr_reg  <= base_addr[back_next];
      end
   end

   assign bus.draw_grant     = grant_reg;
   assign bus.back_address   = back_addr_reg;
   assign bus.front_address  = front_addr_reg;
   assign bus.front_index    = front_reg;
   assign bus.pending        = pending_reg;
   assign bus.swap_count     = swap_reg;
   assign bus.drop_count     = drop_reg;
   assign bus.protocol_error = perr_reg;

endmodule

// File: tb/tb_fb_swap_controller.sv
// Scoreboard bench for fb_swap_controller; the FB_SWAP_THROTTLE_EN build swaps the drop test
// for the WAIT_SPARE test.
module tb_fb_swap_controller;
   localparam logic [29:0] A0 = 30'h3800_0000;
   localparam logic [29:0] A1 = 30'h3817_7000;
   localparam logic [29:0] A2 = 30'h382E_E000;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;

   fb_swap_controller_if bus ();

   fb_swap_controller dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   always #5 clock = ~clock;

   typedef struct {
      string       name;
      logic [1:0]  fi;
      logic [29:0] fa;
      logic [29:0] ba;
      logic        g;
      logic        p;
      logic        pe;
      logic [15:0] sc;
      logic [15:0] dc;
   } snap_t;

   snap_t exp_q[$];
   logic  obs_valid  = 1'b0;
   logic  finish_req = 1'b0;
   int    errors     = 0;
   int    checks     = 0;
   int    txn        = 0;

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic pulse(input logic s, input logic d, input logic n);
      bus.draw_start     = s;
      bus.draw_done      = d;
      bus.lcd_next_frame = n;
      tick();
      bus.draw_start     = 1'b0;
      bus.draw_done      = 1'b0;
      bus.lcd_next_frame = 1'b0;
   endtask

   task automatic check_state(input string nm, input logic [1:0] fi, input logic [29:0] fa,
                              input logic [29:0] ba, input logic g, input logic p,
                              input logic pe, input logic [15:0] sc, input logic [15:0] dc);
      snap_t s;
      s.name = nm; s.fi = fi; s.fa = fa; s.ba = ba;
      s.g = g; s.p = p; s.pe = pe; s.sc = sc; s.dc = dc;
      exp_q.push_back(s);
      obs_valid = 1'b1;
      tick();
      obs_valid = 1'b0;
   endtask

   task automatic do_reset;
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic cmp(input string nm, input string fld, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s.%s actual=%0h required=%0h", nm, fld, act, req);
      end
   endtask

   // Monitor: pops one expected snapshot per presented observation.
   always @(negedge clock) begin
      snap_t s;
      if (obs_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_underflow actual=empty required=entry");
         end else begin
            s = exp_q.pop_front();
            txn++;
            cmp(s.name, "front_index",    32'(bus.front_index),    32'(s.fi));
            cmp(s.name, "front_address",  32'(bus.front_address),  32'(s.fa));
            cmp(s.name, "back_address",   32'(bus.back_address),   32'(s.ba));
            cmp(s.name, "draw_grant",     32'(bus.draw_grant),     32'(s.g));
            cmp(s.name, "pending",        32'(bus.pending),        32'(s.p));
            cmp(s.name, "protocol_error", 32'(bus.protocol_error), 32'(s.pe));
            cmp(s.name, "swap_count",     32'(bus.swap_count),     32'(s.sc));
            cmp(s.name, "drop_count",     32'(bus.drop_count),     32'(s.dc));
            $display("txn %0d %s: front=%0d fa=%h ba=%h grant=%0b pend=%0b", txn, s.name,
                     bus.front_index, bus.front_address, bus.back_address,
                     bus.draw_grant, bus.pending);
         end
      end
      if (finish_req) begin
         checks++;
         if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover actual=%0d required=0", exp_q.size());
         end
         $display("Result: errors=%0d of %0d checks", errors, checks);
         $finish;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.draw_start     = 1'b0;
      bus.draw_done      = 1'b0;
      bus.lcd_next_frame = 1'b0;
      tick();
      tick();
      check_state("in_reset", 2'd0, A0, A2, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
      reset_n = 1'b1;
      tick();
      check_state("reset", 2'd0, A0, A2, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);

      // Frame pulse with nothing pending leaves everything in place.
      pulse(1'b0, 1'b0, 1'b1);
      check_state("nf_no_pending", 2'd0, A0, A2, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);

      // Single draw then promotion.
      pulse(1'b1, 1'b0, 1'b0);
      check_state("grant_rise", 2'd0, A0, A2, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
      pulse(1'b1, 1'b0, 1'b0);
      repeat (8) tick();
      check_state("drawing", 2'd0, A0, A2, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
      pulse(1'b0, 1'b1, 1'b0);
      check_state("done", 2'd0, A0, A1, 1'b0, 1'b1, 1'b0, 16'd0, 16'd0);
      pulse(1'b0, 1'b0, 1'b1);
      check_state("promote", 2'd2, A2, A1, 1'b0, 1'b0, 1'b0, 16'd1, 16'd0);
      do_reset();

`ifndef FB_SWAP_THROTTLE_EN
      // Two finished frames, no display: first is dropped, second is shown.
      pulse(1'b1, 1'b0, 1'b0);
      pulse(1'b0, 1'b1, 1'b0);
      pulse(1'b1, 1'b0, 1'b0);
      pulse(1'b0, 1'b1, 1'b0);
      check_state("drop", 2'd0, A0, A2, 1'b0, 1'b1, 1'b0, 16'd0, 16'd1);
      pulse(1'b0, 1'b0, 1'b1);
      check_state("show_second", 2'd1, A1, A2, 1'b0, 1'b0, 1'b0, 16'd1, 16'd1);
      do_reset();
`endif

      // draw_done and lcd_next_frame on the same edge.
      pulse(1'b1, 1'b0, 1'b0);
      pulse(1'b0, 1'b1, 1'b1);
      check_state("same_edge", 2'd2, A2, A1, 1'b0, 1'b0, 1'b0, 16'd1, 16'd0);
      pulse(1'b1, 1'b0, 1'b0);
      pulse(1'b0, 1'b1, 1'b0);
      check_state("spare_was_0", 2'd2, A2, A0, 1'b0, 1'b1, 1'b0, 16'd1, 16'd0);
      do_reset();

      // Stray draw_done, then asynchronous reset in the middle of a draw.
      pulse(1'b0, 1'b1, 1'b0);
      check_state("protocol_err", 2'd0, A0, A2, 1'b0, 1'b0, 1'b1, 16'd0, 16'd0);
      pulse(1'b1, 1'b0, 1'b0);
      check_state("grant_after_err", 2'd0, A0, A2, 1'b1, 1'b0, 1'b1, 16'd0, 16'd0);
      pulse(1'b0, 1'b1, 1'b0);
      check_state("err_done", 2'd0, A0, A1, 1'b0, 1'b1, 1'b1, 16'd0, 16'd0);
      pulse(1'b1, 1'b0, 1'b0);
      #2;
      reset_n = 1'b0;
      check_state("async_reset", 2'd0, A0, A2, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
      reset_n = 1'b1;
      tick();

`ifdef FB_SWAP_THROTTLE_EN
      // Draw request with a pending frame waits for the promoting frame pulse.
      pulse(1'b1, 1'b0, 1'b0);
      pulse(1'b0, 1'b1, 1'b0);
      pulse(1'b1, 1'b0, 1'b0);
      check_state("wait_spare", 2'd0, A0, A1, 1'b0, 1'b1, 1'b0, 16'd0, 16'd0);
      pulse(1'b1, 1'b0, 1'b0);
      repeat (3) tick();
      check_state("still_waiting", 2'd0, A0, A1, 1'b0, 1'b1, 1'b0, 16'd0, 16'd0);
      pulse(1'b0, 1'b0, 1'b1);
      check_state("nf_plus1", 2'd2, A2, A1, 1'b0, 1'b0, 1'b0, 16'd1, 16'd0);
      check_state("nf_plus2", 2'd2, A2, A1, 1'b1, 1'b0, 1'b0, 16'd1, 16'd0);
      pulse(1'b0, 1'b1, 1'b0);
      check_state("throttle_done", 2'd2, A2, A0, 1'b0, 1'b1, 1'b0, 16'd1, 16'd0);
`endif

      finish_req = 1'b1;
      tick();
      tick();
   end
endmodule
